// File: rtl/hazard_scoreboard.sv
// Register-write scoreboard for in-order issue: per-register pending-write counters gate the ID stage.
// Optional WB-stage forwarding awareness is enabled by defining HAZARD_SB_WB_BYPASS_EN.
module hazard_scoreboard #(
  parameter int unsigned NR_XREG = 32,
  parameter int unsigned NSRC    = 2,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned OUT_MAX = 4,
  parameter int unsigned IDX_W   = $clog2(NR_XREG)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    issue_valid,
  input  logic                    issue_rd_w_en,
  input  logic [IDX_W-1:0]        issue_rd,
  input  logic [NSRC*IDX_W-1:0]   issue_rs,
  input  logic [NSRC-1:0]         issue_rs_use,
  input  logic                    commit_valid,
  input  logic [IDX_W-1:0]        commit_rd,
  input  logic                    flush,
  output logic                    issue_ready,
  output logic                    if_id_stall,
  output logic [NR_XREG-1:0]      busy_vec,
  output logic                    sb_err
);

  // Total needs headroom of one above OUT_MAX so an overflow attempt is representable.
  localparam int unsigned TOT_W = $clog2(OUT_MAX + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NR_XREG];
  logic [CNT_W-1:0] cnt_d [NR_XREG];
  logic [TOT_W-1:0] total_q;
  logic [TOT_W-1:0] total_d;
  logic             sb_err_q;

  logic             src_hazard;
  logic             rd_block;
  logic             fire;
  logic             inc;
  logic             dec_req;
  logic             dec;
  logic             same_rd;
  logic             underflow;
  logic             overflow;
  logic [IDX_W-1:0] rs_k;
  logic             bypass_k;

  // Source hazard detection across all operand ports.
  always_comb begin
    src_hazard = 1'b0;
    rs_k       = '0;
    bypass_k   = 1'b0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      rs_k = issue_rs[k*IDX_W +: IDX_W];
`ifdef HAZARD_SB_WB_BYPASS_EN
      bypass_k = commit_valid && (commit_rd == rs_k) && (cnt_q[rs_k] == CNT_W'(1));
`else
      bypass_k = 1'b0;
`endif
      if (issue_rs_use[k] && (rs_k != '0) && (cnt_q[rs_k] != '0) && !bypass_k) begin
        src_hazard = 1'b1;
      end
    end
  end

  // Destination capacity: per-register counter full or global in-flight limit reached.
  always_comb begin
    rd_block = 1'b0;
    if (issue_rd_w_en && (issue_rd != '0)) begin
      rd_block = (cnt_q[issue_rd] == CNT_MAX) || (total_q >= TOT_W'(OUT_MAX));
    end
  end

  assign issue_ready = !(src_hazard || rd_block);
  assign if_id_stall = issue_valid && !issue_ready;
  assign fire        = issue_valid && issue_ready && !flush;

  // Update qualifiers; a commit to an empty counter is an error and changes nothing.
  always_comb begin
    inc       = fire && issue_rd_w_en && (issue_rd != '0);
    dec_req   = commit_valid && (commit_rd != '0);
    dec       = dec_req && (cnt_q[commit_rd] != '0);
    underflow = dec_req && (cnt_q[commit_rd] == '0);
    same_rd   = inc && dec && (issue_rd == commit_rd);
    overflow  = inc && !dec && (total_q >= TOT_W'(OUT_MAX));
  end

  // Next counter values; matching issue/commit on one register cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !same_rd) begin
      cnt_d[issue_rd] = cnt_q[issue_rd] + CNT_W'(1);
    end
    if (dec && !same_rd) begin
      cnt_d[commit_rd] = cnt_q[commit_rd] - CNT_W'(1);
    end
  end

  always_comb begin
    total_d = total_q;
    if (inc && !dec) begin
      total_d = total_q + TOT_W'(1);
    end else if (dec && !inc) begin
      total_d = total_q - TOT_W'(1);
    end
  end

  // State registers; flush empties the board but leaves the sticky error alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NR_XREG; r++) begin
        cnt_q[r] <= '0;
      end
      total_q  <= '0;
      sb_err_q <= 1'b0;
    end else if (flush) begin
      for (int unsigned r = 0; r < NR_XREG; r++) begin
        cnt_q[r] <= '0;
      end
      total_q <= '0;
    end else begin
      for (int unsigned r = 0; r < NR_XREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      total_q <= total_d;
      if (underflow || overflow) begin
        sb_err_q <= 1'b1;
      end
    end
  end

  // Busy view derives only from registered counters; x0 is never reported.
  always_comb begin
    busy_vec = '0;
    for (int unsigned r = 1; r < NR_XREG; r++) begin
      busy_vec[r] = (cnt_q[r] != '0);
    end
  end

  assign sb_err = sb_err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized traffic
// compared against a counting reference model.
module tb_hazard_scoreboard;

  localparam int unsigned NR_XREG = 32;
  localparam int unsigned NSRC    = 2;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned OUT_MAX = 4;
  localparam int unsigned IDX_W   = 5;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  issue_valid;
  logic                  issue_rd_w_en;
  logic [IDX_W-1:0]      issue_rd;
  logic [NSRC*IDX_W-1:0] issue_rs;
  logic [NSRC-1:0]       issue_rs_use;
  logic                  commit_valid;
  logic [IDX_W-1:0]      commit_rd;
  logic                  flush;
  logic                  issue_ready;
  logic                  if_id_stall;
  logic [NR_XREG-1:0]    busy_vec;
  logic                  sb_err;

  int checks = 0;
  int errors = 0;
  int m_cnt [NR_XREG];
  bit m_err;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NR_XREG(NR_XREG), .NSRC(NSRC), .CNT_W(CNT_W), .OUT_MAX(OUT_MAX), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rd_w_en(issue_rd_w_en), .issue_rd(issue_rd),
    .issue_rs(issue_rs), .issue_rs_use(issue_rs_use),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .flush(flush),
    .issue_ready(issue_ready), .if_id_stall(if_id_stall),
    .busy_vec(busy_vec), .sb_err(sb_err)
  );

  function automatic int m_sum();
    int s = 0;
    for (int r = 1; r < NR_XREG; r++) s += m_cnt[r];
    return s;
  endfunction

  function automatic bit exp_ready();
    bit ok = 1'b1;
    for (int k = 0; k < NSRC; k++) begin
      int rs;
      bit byp;
      rs  = int'(issue_rs[k*IDX_W +: IDX_W]);
      byp = 1'b0;
`ifdef HAZARD_SB_WB_BYPASS_EN
      byp = commit_valid && (int'(commit_rd) == rs) && (m_cnt[rs] == 1);
`endif
      if (issue_rs_use[k] && rs != 0 && m_cnt[rs] > 0 && !byp) ok = 1'b0;
    end
    if (issue_rd_w_en && issue_rd != 0 &&
        (m_cnt[issue_rd] == (1 << CNT_W) - 1 || m_sum() == OUT_MAX)) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [NR_XREG-1:0] exp_busy();
    logic [NR_XREG-1:0] b = '0;
    for (int r = 1; r < NR_XREG; r++) b[r] = (m_cnt[r] > 0);
    return b;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR_XREG; r++) m_cnt[r] = 0;
    m_err = 1'b0;
  endtask

  task automatic set_idle();
    issue_valid = 0; issue_rd_w_en = 0; issue_rd = '0; issue_rs = '0;
    issue_rs_use = '0; commit_valid = 0; commit_rd = '0; flush = 0;
  endtask

  task automatic drive_issue(input bit v, input bit w, input int rd, input int rs0,
                             input int rs1, input logic [1:0] use_f);
    issue_valid = v; issue_rd_w_en = w; issue_rd = IDX_W'(rd);
    issue_rs = {IDX_W'(rs1), IDX_W'(rs0)}; issue_rs_use = use_f;
  endtask

  // Advance the model by the current-cycle inputs, then move to the next negedge.
  task automatic tick();
    bit f;
    int pre [NR_XREG];
    f = issue_valid && exp_ready() && !flush;
    if (flush) begin
      for (int r = 0; r < NR_XREG; r++) m_cnt[r] = 0;
    end else begin
      pre = m_cnt;
      if (commit_valid && commit_rd != 0) begin
        if (pre[commit_rd] == 0) m_err = 1'b1;
        else m_cnt[commit_rd]--;
      end
      if (f && issue_rd_w_en && issue_rd != 0) m_cnt[issue_rd]++;
      if (m_sum() > OUT_MAX) m_err = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_board();
    set_idle(); flush = 1; tick(); set_idle();
  endtask

  task automatic test_reset();
    rst_n = 0;
    set_idle();
    model_reset();
    drive_issue(1, 1, 5, 5, 6, 2'b11);
    #1;
    checks++; if (busy_vec !== '0) begin errors++; $display("FAIL reset_busy: got %0h want 0", busy_vec); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", sb_err); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", issue_ready); end
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    set_idle();
  endtask

  task automatic test_raw();
    clear_board();
    drive_issue(1, 1, 5, 0, 0, 2'b00); #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL raw_first: got %0b want 1", issue_ready); end
    tick();
    for (int i = 0; i < 2; i++) begin
      drive_issue(1, 0, 0, 5, 0, 2'b01); #1;
      checks++; if (if_id_stall !== 1'b1) begin errors++; $display("FAIL raw_stall: got %0b want 1", if_id_stall); end
      checks++; if (busy_vec !== 32'h20) begin errors++; $display("FAIL raw_busy: got %0h want 20", busy_vec); end
      tick();
    end
    commit_valid = 1; commit_rd = 5; #1;
`ifdef HAZARD_SB_WB_BYPASS_EN
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL raw_commit_cycle: got %0b want 1", issue_ready); end
`else
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL raw_commit_cycle: got %0b want 0", issue_ready); end
`endif
    tick();
    commit_valid = 0; #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL raw_after_commit: got %0b want 1", issue_ready); end
    checks++; if (busy_vec !== '0) begin errors++; $display("FAIL raw_busy_clear: got %0h want 0", busy_vec); end
    tick();
    set_idle();
  endtask

  task automatic test_counter_sat();
    clear_board();
    for (int i = 0; i < 3; i++) begin
      drive_issue(1, 1, 7, 0, 0, 2'b00); #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL sat_issue%0d: got %0b want 1", i, issue_ready); end
      tick();
    end
    drive_issue(1, 1, 7, 0, 0, 2'b00); #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL sat_fourth: got %0b want 0", issue_ready); end
    checks++; if (busy_vec !== 32'h80) begin errors++; $display("FAIL sat_busy: got %0h want 80", busy_vec); end
    tick();
    commit_valid = 1; commit_rd = 7; #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL sat_commit_cycle: got %0b want 0", issue_ready); end
    tick();
    commit_valid = 0; #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL sat_unblock: got %0b want 1", issue_ready); end
    tick();
    set_idle();
  endtask

  task automatic test_out_max();
    clear_board();
    for (int r = 1; r <= 4; r++) begin
      drive_issue(1, 1, r, 0, 0, 2'b00); tick();
    end
    drive_issue(1, 1, 6, 0, 0, 2'b00); #1;
    checks++; if (if_id_stall !== 1'b1) begin errors++; $display("FAIL omax_stall: got %0b want 1", if_id_stall); end
    drive_issue(1, 0, 0, 8, 0, 2'b01); #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL omax_src8: got %0b want 1", issue_ready); end
    drive_issue(1, 1, 0, 0, 0, 2'b11); #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL omax_x0: got %0b want 1", issue_ready); end
    checks++; if (busy_vec !== 32'h1E) begin errors++; $display("FAIL omax_busy: got %0h want 1e", busy_vec); end
    tick();
    set_idle();
  endtask

  task automatic test_same_cycle();
    clear_board();
    drive_issue(1, 1, 3, 0, 0, 2'b00); tick();
    commit_valid = 1; commit_rd = 3; #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL same_ready: got %0b want 1", issue_ready); end
    tick();
    set_idle(); #1;
    checks++; if (busy_vec !== 32'h8) begin errors++; $display("FAIL same_busy: got %0h want 8", busy_vec); end
    commit_valid = 1; commit_rd = 3; tick();
    set_idle(); #1;
    checks++; if (busy_vec !== '0) begin errors++; $display("FAIL same_drain: got %0h want 0", busy_vec); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL same_err: got %0b want 0", sb_err); end
  endtask

  task automatic test_flush();
    clear_board();
    for (int r = 4; r <= 7; r++) begin
      drive_issue(1, 1, r, 0, 0, 2'b00); tick();
    end
    set_idle(); #1;
    checks++; if (busy_vec !== 32'hF0) begin errors++; $display("FAIL flush_pre: got %0h want f0", busy_vec); end
    drive_issue(1, 1, 9, 0, 0, 2'b00); commit_valid = 1; commit_rd = 4; flush = 1; tick();
    set_idle(); #1;
    checks++; if (busy_vec !== '0) begin errors++; $display("FAIL flush_busy: got %0h want 0", busy_vec); end
    drive_issue(1, 0, 0, 9, 0, 2'b01); #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL flush_rd9: got %0b want 1", issue_ready); end
    tick();
    set_idle();
  endtask

  task automatic test_err_and_reset();
    clear_board();
    commit_valid = 1; commit_rd = 12; tick();
    set_idle(); #1;
    checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL err_set: got %0b want 1", sb_err); end
    flush = 1; tick(); tick();
    set_idle(); #1;
    checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL err_hold: got %0b want 1", sb_err); end
    drive_issue(1, 1, 2, 0, 0, 2'b00); tick();
    drive_issue(1, 0, 0, 2, 0, 2'b01); #2;
    rst_n = 0; model_reset(); #1;
    checks++; if (busy_vec !== '0) begin errors++; $display("FAIL rst_busy: got %0h want 0", busy_vec); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b want 0", sb_err); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b want 1", issue_ready); end
    @(negedge clk);
    rst_n = 1; #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rst_release: got %0b want 1", issue_ready); end
    tick();
    set_idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      int c;
      set_idle();
      drive_issue($urandom_range(99) < 75, $urandom_range(99) < 60, $urandom_range(7),
                  $urandom_range(7), $urandom_range(7), 2'($urandom_range(3)));
      if ($urandom_range(99) < 45) begin
        c = 0;
        for (int t = 0; t < 8 && c == 0; t++) begin
          int r = $urandom_range(1, 7);
          if (m_cnt[r] > 0) c = r;
        end
        if (c == 0 && $urandom_range(99) < 10) c = $urandom_range(1, 7);
        commit_valid = (c != 0) || ($urandom_range(99) < 5);
        commit_rd = IDX_W'(c);
      end
      flush = ($urandom_range(99) < 3);
      #1;
      checks++; if (issue_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready[%0d]: got %0b want %0b", n, issue_ready, exp_ready()); end
      checks++; if (if_id_stall !== (issue_valid && !exp_ready())) begin errors++; $display("FAIL rnd_stall[%0d]: got %0b want %0b", n, if_id_stall, issue_valid && !exp_ready()); end
      checks++; if (busy_vec !== exp_busy()) begin errors++; $display("FAIL rnd_busy[%0d]: got %0h want %0h", n, busy_vec, exp_busy()); end
      checks++; if (sb_err !== m_err) begin errors++; $display("FAIL rnd_err[%0d]: got %0b want %0b", n, sb_err, m_err); end
      tick();
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_counter_sat();
    test_out_max();
    test_same_cycle();
    test_flush();
    test_err_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NR_XREG, default 32: number of architectural integer registers; x0 is never tracked.
REQ-002 SHALL have parameter NSRC, default 2: source-operand ports checked per issue.
REQ-003 SHALL have parameter CNT_W, default 2: width of each per-register pending-write counter.
REQ-004 SHALL have parameter OUT_MAX, default 4: maximum total in-flight writes.
REQ-005 SHALL have derived parameter IDX_W = $clog2(NR_XREG).
REQ-006 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port issue_valid, input, 1: ID stage presents an instruction.
REQ-009 SHALL have port issue_rd_w_en, input, 1: the instruction writes rd.
REQ-010 SHALL have port issue_rd, input, IDX_W: destination register.
REQ-011 SHALL have port issue_rs, input, NSRC*IDX_W: source registers; port k occupies bits [k*IDX_W +: IDX_W].
REQ-012 SHALL have port issue_rs_use, input, NSRC: per-port source-used flag.
REQ-013 SHALL have port commit_valid, input, 1: a tracked write retires at WB this cycle.
REQ-014 SHALL have port commit_rd, input, IDX_W: register retired.
REQ-015 SHALL have port flush, input, 1: pipeline flush; drops all in-flight writes.
REQ-016 SHALL have port issue_ready, output, 1: issue accepted this cycle.
REQ-017 SHALL have port if_id_stall, output, 1: equals ~issue_ready & issue_valid.
REQ-018 SHALL have port busy_vec, output, NR_XREG: bit r set when counter[r] != 0.
REQ-019 SHALL have port sb_err, output, 1: sticky underflow/overflow error.

Function
REQ-020 SHALL define fire = issue_valid & issue_ready & ~flush.
REQ-021 SHALL define a source hazard as port k with issue_rs_use[k]=1, rs != 0 and counter[rs] != 0.
REQ-022 SHALL deassert issue_ready when any of: a source hazard; issue_rd_w_en with rd != 0 and counter[rd] = 2^CNT_W-1; issue_rd_w_en with rd != 0 and total = OUT_MAX.
REQ-023 SHALL compute issue_ready combinationally, with zero-cycle latency from inputs and state.
REQ-024 SHALL, on fire with issue_rd_w_en and rd != 0, increment counter[rd] and total at the next edge.
REQ-025 SHALL, on commit_valid with commit_rd != 0 and counter != 0, decrement counter[commit_rd] and total at the next edge.
REQ-026 SHALL, on commit_valid to a zero counter, leave the counter unchanged and set sb_err.
REQ-027 SHALL, when fire and commit target the same rd in one cycle, leave counter[rd] and total unchanged.
REQ-028 SHALL, when fire and commit target different registers in one cycle, apply both updates and leave total unchanged.
REQ-029 SHALL ignore writes to x0 on both issue and commit; x0 is never a hazard.
REQ-030 SHALL give flush priority over all other inputs: all counters and total go to 0 at the next edge, and issue and commit in that cycle are discarded; sb_err is unaffected.
REQ-031 SHALL keep total equal to the sum of all counters at every edge.
REQ-032 SHALL set sb_err if total would exceed OUT_MAX; sb_err clears only on reset.
REQ-033 SHALL drive busy_vec from registered state only, with no combinational input path.

Reset
REQ-034 SHALL, while rst_n=0, asynchronously clear every counter, total and sb_err, so busy_vec=0 and issue_ready=issue_valid-independent 1.
REQ-035 SHALL, on reset asserted mid-operation, discard all pending writes; the first edge after release sees an empty scoreboard.

Configuration
REQ-036 SHALL provide macro HAZARD_SB_WB_BYPASS_EN.
REQ-037 SHALL, when HAZARD_SB_WB_BYPASS_EN is defined, exclude a source from hazard when commit_valid is high, commit_rd equals rs and counter[rs]=1, because the WB value is forwarded this cycle.
REQ-038 SHALL, when HAZARD_SB_WB_BYPASS_EN is undefined, stall on any nonzero counter regardless of same-cycle commit.

Verification
REQ-039 SHALL cover: issue rd=5 and write, next cycle issue rs1=5 -> if_id_stall=1 until commit rd=5, then issue_ready=1 the cycle after, or the same cycle with bypass.
REQ-040 SHALL cover: with CNT_W=2, three issues writing rd=7 then a fourth -> fourth stalls, counter[7]=3, and one commit unblocks it.
REQ-041 SHALL cover: four writes to x1-x4 with OUT_MAX=4, then a write to x6 -> stall; a source reading x8 alone -> no stall.
REQ-042 SHALL cover: same-cycle fire rd=3 and commit rd=3 with counter[3]=1 -> counter[3] stays 1 and busy_vec[3]=1.
REQ-043 SHALL cover: flush with busy_vec=0x0000_00F0 and concurrent issue to rd=9 -> busy_vec=0 next cycle and rd=9 not tracked.
REQ-044 SHALL cover: commit rd=12 with counter[12]=0 -> sb_err=1 and held; rst_n low mid-run -> all outputs at reset values immediately.
